// File: rtl/mem_addr_sequencer_pkg.sv
// Shared definitions for the memory-sweep sequencer.
//   state_t   : FSM encoding, also the value driven on the state output
//   M_*       : sweep mode codes carried on the mode input
//   is_active : true in the states that issue RAM strobes
package mem_addr_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] M_WR    = 2'b00;
  localparam logic [1:0] M_RD    = 2'b01;
  localparam logic [1:0] M_WR_RD = 2'b10;

  function automatic logic is_active(input state_t s);
    return (s == S_WRITE) || (s == S_READ);
  endfunction

endpackage

// File: rtl/mem_addr_stepper.sv
// Up/down modulo-DEPTH address register.
//   clk, rst : clock and asynchronous active-low reset (addr clears to 0)
//   load     : addr takes value on the next edge (priority over en)
//   value    : load value
//   en       : step addr by one on the next edge
//   dir      : 0 = +1 (DEPTH-1 wraps to 0), 1 = -1 (0 wraps to DEPTH-1)
//   addr     : registered address
module mem_addr_stepper #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] value,
  input  logic              en,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= value;
    end else if (en) begin
      if (dir) addr <= (addr == '0)   ? LAST : addr - ONE;
      else     addr <= (addr == LAST) ? '0   : addr + ONE;
    end
  end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Memory-sweep sequencer: generates address/strobe streams for a RAM port
// (write sweep, read sweep, or write-then-read sweep) over base/len, up or down,
// with optional modulo-DEPTH wrap.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : sweep request, sampled only in IDLE
//   mode      : 00 write, 01 read, 10 write-then-read, 11 rejected
//   dir       : 0 ascending, 1 descending
//   wrap_en   : 1 wrap modulo DEPTH, 0 reject ranges that would cross an end
//   base, len : first address, words per phase
//   stall     : suppress the strobe of the next cycle without losing the access
//   abort     : drop the sweep, back to IDLE next cycle (beats stall)
//   mem_addr, mem_we, mem_re : registered RAM port
//   state     : FSM state (IDLE/WRITE/READ/DONE), busy : in WRITE or READ
//   done, err : one-cycle completion pulse, err marks a rejected request
//
// Handshake: a request is a single-cycle start pulse taken only while state is
// IDLE; it is answered by exactly one done pulse unless abort or reset cuts the
// sweep short. start outside IDLE is dropped, never queued.
module mem_addr_sequencer
  import mem_addr_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic              wrap_en,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              stall,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q, state_n;
  logic                we_q, we_n, re_q, re_n;
  logic                done_q, done_n, err_q, err_n, busy_q;
  logic [ADDR_W:0]     cnt_q, cnt_n;   // strobes issued in this phase, including the one on the port now
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [1:0]          mode_q;
  logic                dir_q;
  logic                capture;
  logic                reject;
  logic                step_load, step_en;
  logic [ADDR_W-1:0]   step_value;
  logic                strobe_q;

  assign strobe_q = we_q | re_q;

  // Request check. With wrap disabled the sweep must stay inside 0..DEPTH-1
  // in its own direction; with wrap enabled any in-range base is fine.
  always_comb begin
    reject = 1'b0;
    if (len == '0 || int'(len) > DEPTH || mode == 2'b11 || int'(base) >= DEPTH) begin
      reject = 1'b1;
    end else if (!wrap_en) begin
      if (!dir && (int'(base) + int'(len) > DEPTH)) reject = 1'b1;
      if (dir && (int'(len) > int'(base) + 1))      reject = 1'b1;
    end
  end

  always_comb begin
    state_n    = state_q;
    we_n       = 1'b0;
    re_n       = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    cnt_n      = cnt_q;
    capture    = 1'b0;
    step_load  = 1'b0;
    step_value = base_q;
    step_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (reject) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            step_load  = 1'b1;
            step_value = base;
            cnt_n      = CNT_ONE;
            if (mode == M_RD) begin
              state_n = S_READ;
              re_n    = 1'b1;
            end else begin
              state_n = S_WRITE;
              we_n    = 1'b1;
            end
          end
        end
      end
      S_WRITE, S_READ: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (strobe_q && cnt_q == len_q) begin
          // Last strobe of the phase is on the port now.
          if (state_q == S_WRITE && mode_q == M_WR_RD) begin
            state_n    = S_READ;
            step_load  = 1'b1;
            step_value = base_q;
            re_n       = !stall;
            cnt_n      = stall ? '0 : CNT_ONE;
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end
        end else begin
          // Advance past an address only once its strobe has actually gone out;
          // a stalled cycle re-presents the same address next time.
          step_en = strobe_q;
          if (!stall) begin
            we_n  = (state_q == S_WRITE);
            re_n  = (state_q == S_READ);
            cnt_n = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      mode_q  <= M_WR;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      we_q    <= we_n;
      re_q    <= re_n;
      done_q  <= done_n;
      err_q   <= err_n;
      busy_q  <= is_active(state_n);
      cnt_q   <= cnt_n;
      if (capture) begin
        base_q <= base;
        len_q  <= len;
        mode_q <= mode;
        dir_q  <= dir;
      end
    end
  end

  mem_addr_stepper #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_stepper (
    .clk  (clk),
    .rst  (rst),
    .load (step_load),
    .value(step_value),
    .en   (step_en),
    .dir  (dir_q),
    .addr (mem_addr)
  );

  assign mem_we = we_q;
  assign mem_re = re_q;
  assign state  = state_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Bench for mem_addr_sequencer (ADDR_W=4, DEPTH=16). One expected output word
// per clock cycle is queued before each sweep and popped on every falling edge.
// Word layout: {state, busy, done, err, mem_we, mem_re, mem_addr}.
module tb_mem_addr_sequencer;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int W      = 11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              dir = 1'b0;
  logic              wrap_en = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0]   len = '0;
  logic              stall = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [1:0]        state;
  logic              busy;
  logic              done;
  logic              err;

  logic [W-1:0]      obs;
  logic [W-1:0]      exp_q[$];
  int                cmp_cnt = 0;
  int                fail_cnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  int                ncyc;

  mem_addr_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .dir     (dir),
    .wrap_en (wrap_en),
    .base    (base),
    .len     (len),
    .stall   (stall),
    .abort   (abort),
    .mem_addr(mem_addr),
    .mem_we  (mem_we),
    .mem_re  (mem_re),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  assign obs = {state, busy, done, err, mem_we, mem_re, mem_addr};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input logic [1:0] st, input logic we, input logic re,
                                        input logic [ADDR_W-1:0] a, input logic dn, input logic er);
    logic bz;
    bz = (st == ST_WRITE) || (st == ST_READ);
    return {st, bz, dn, er, we, re, a};
  endfunction

  function automatic logic [W-1:0] pk_w(input int a);
    return pack(ST_WRITE, 1'b1, 1'b0, ADDR_W'(a), 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] pk_r(input int a);
    return pack(ST_READ, 1'b0, 1'b1, ADDR_W'(a), 1'b0, 1'b0);
  endfunction

  // Expected words of a stall-free sweep: strobes, one DONE cycle, one IDLE cycle.
  task automatic push_sweep(input logic [1:0] m, input int b, input logic d, input int n,
                            output int cycles);
    int a;
    a = b;
    cycles = 0;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1 && m != 2'b10) break;
      for (int k = 0; k < n; k++) begin
        a = d ? (b - k + 2 * DEPTH) % DEPTH : (b + k) % DEPTH;
        if (ph == 0 && m != 2'b01) exp_q.push_back(pk_w(a));
        else                       exp_q.push_back(pk_r(a));
        cycles++;
      end
    end
    exp_addr = ADDR_W'(a);
    exp_q.push_back(pack(ST_DONE, 1'b0, 1'b0, exp_addr, 1'b1, 1'b0));
    exp_q.push_back(pack(ST_IDLE, 1'b0, 1'b0, exp_addr, 1'b0, 1'b0));
    cycles += 2;
  endtask

  // ---------------- driver ----------------
  task automatic drive_start(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                             input logic [ADDR_W:0] n, input logic d, input logic w);
    mode    = m;
    base    = b;
    len     = n;
    dir     = d;
    wrap_en = w;
    start   = 1'b1;
  endtask

  // Advance one cycle; outputs are sampled on the falling edge, and the
  // single-cycle pulses start/abort are dropped there.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic [W-1:0] e;
    cmp_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL %s: observed %h with no expected entry queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fail_cnt++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rm;
    int         rb, rn;
    logic       rd;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back('0);
    check("reset");
    rst = 1'b1;

    // 1. write sweep up: addr 3,4,5,6 then done
    push_sweep(2'b00, 3, 1'b0, 4, ncyc);
    drive_start(2'b00, 4'd3, 5'd4, 1'b0, 1'b0);
    run(ncyc, "t1_write_up");

    // 2. read sweep down with wrap: addr 1,0,15,14
    push_sweep(2'b01, 1, 1'b1, 4, ncyc);
    drive_start(2'b01, 4'd1, 5'd4, 1'b1, 1'b1);
    run(ncyc, "t2_read_down_wrap");

    // 3. rejects: done+err in cycle 1, address untouched
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(pack(ST_DONE, 1'b0, 1'b0, exp_addr, 1'b1, 1'b1));
      exp_q.push_back(pack(ST_IDLE, 1'b0, 1'b0, exp_addr, 1'b0, 1'b0));
      case (r)
        0:       drive_start(2'b00, 4'd14, 5'd4, 1'b0, 1'b0);  // crosses DEPTH-1
        1:       drive_start(2'b01, 4'd0,  5'd0, 1'b0, 1'b1);  // len 0
        2:       drive_start(2'b11, 4'd2,  5'd2, 1'b0, 1'b1);  // reserved mode
        default: drive_start(2'b00, 4'd2,  5'd4, 1'b1, 1'b0);  // crosses 0 going down
      endcase
      run(2, "t3_reject");
    end

    // 4. write-then-read, stall in cycle 2
    exp_q.push_back(pk_w(0));
    exp_q.push_back(pk_w(1));
    exp_q.push_back(pack(ST_WRITE, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    exp_q.push_back(pk_w(2));
    exp_q.push_back(pk_r(0));
    exp_q.push_back(pk_r(1));
    exp_q.push_back(pk_r(2));
    exp_q.push_back(pack(ST_DONE, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
    exp_q.push_back(pack(ST_IDLE, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    exp_addr = 4'd2;
    drive_start(2'b10, 4'd0, 5'd3, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("t4_wr_rd_stall");
      stall = (c == 2);
    end

    // 5. start while busy ignored, abort in cycle 3, done never raised
    exp_q.push_back(pk_w(0));
    exp_q.push_back(pk_w(1));
    exp_q.push_back(pk_w(2));
    for (int c = 0; c < 3; c++) exp_q.push_back(pack(ST_IDLE, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
    exp_addr = 4'd2;
    drive_start(2'b00, 4'd0, 5'd8, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("t5_abort");
      if (c == 2) drive_start(2'b01, 4'd7, 5'd2, 1'b1, 1'b1);
      if (c == 3) abort = 1'b1;
    end

    // 6. reset in the middle of a sweep, then a one-word sweep
    exp_q.push_back(pk_w(0));
    exp_q.push_back(pk_w(1));
    exp_q.push_back(pk_w(2));
    drive_start(2'b00, 4'd0, 5'd8, 1'b0, 1'b0);
    run(3, "t6_pre_reset");
    #2 rst = 1'b0;
    #1;
    exp_q.push_back('0);
    check("t6_reset_async");
    @(negedge clk);
    exp_q.push_back('0);
    check("t6_reset_held");
    rst = 1'b1;
    push_sweep(2'b00, 5, 1'b0, 1, ncyc);
    drive_start(2'b00, 4'd5, 5'd1, 1'b0, 1'b0);
    run(ncyc, "t6_after_reset");

    // 7. random wrapping sweeps
    for (int it = 0; it < 6; it++) begin
      rm = 2'($urandom_range(0, 2));
      rb = int'($urandom_range(0, DEPTH - 1));
      rn = int'($urandom_range(1, DEPTH));
      rd = 1'($urandom_range(0, 1));
      push_sweep(rm, rb, rd, rn, ncyc);
      drive_start(rm, ADDR_W'(rb), (ADDR_W+1)'(rn), rd, 1'b1);
      run(ncyc, "t7_random");
    end

    cmp_cnt++;
    assert (exp_q.size() == 0) else begin
      fail_cnt++;
      $error("FAIL queue_drained: observed %0d entries left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
